// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle MIPS controller.
// The controller owns the master side: it samples opcode/zero/ready and
// drives every datapath select, enable and status pulse.
interface multicycle_control_if #(
  parameter int ALU_OP_W = 3
);
  // Inputs to the controller
  logic [5:0]          opcode_i;
  logic                zero_i;
  logic                mem_ready_i;

  // Datapath controls
  logic                pc_write_o;
  logic                ir_write_o;
  logic                ior_o;
  logic                mem_read_o;
  logic                mem_write_o;
  logic [1:0]          mem_to_reg_o;
  logic [1:0]          reg_dst_o;
  logic                reg_write_o;
  logic                alu_src_a_o;
  logic [1:0]          alu_src_b_o;
  logic [1:0]          pc_src_o;
  logic [ALU_OP_W-1:0] alu_op_o;

  // Status
  logic [3:0]          state_o;
  logic                illegal_o;
  logic                timeout_o;

  modport master (
    input  opcode_i, zero_i, mem_ready_i,
    output pc_write_o, ir_write_o, ior_o, mem_read_o, mem_write_o,
           mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o,
           pc_src_o, alu_op_o, state_o, illegal_o, timeout_o
  );

  modport slave (
    output opcode_i, zero_i, mem_ready_i,
    input  pc_write_o, ir_write_o, ior_o, mem_read_o, mem_write_o,
           mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o,
           pc_src_o, alu_op_o, state_o, illegal_o, timeout_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB for R, ADDI, LUI, ORI, ANDI, LW, SW,
// BEQ, BNE, J and JAL. Datapath controls are Moore decodes of the state;
// pc_write, ir_write and the illegal/timeout pulses also look at inputs.
// Memory states wait on mem_ready_i and give up after MAX_WAIT stalled
// cycles (0 disables the limit), restarting at FETCH with the same PC.
module multicycle_control #(
  parameter int ALU_OP_W = 3,
  parameter int MAX_WAIT = 15
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  multicycle_control_if.master bus
);

  // State encoding, kept as plain constants so state_o matches legacy dumps
  localparam logic [3:0] S_FETCH    = 4'h0;
  localparam logic [3:0] S_DECODE   = 4'h1;
  localparam logic [3:0] S_MEM_ADDR = 4'h2;
  localparam logic [3:0] S_MEM_RD   = 4'h3;
  localparam logic [3:0] S_MEM_WB   = 4'h4;
  localparam logic [3:0] S_MEM_WR   = 4'h5;
  localparam logic [3:0] S_EXEC_R   = 4'h6;
  localparam logic [3:0] S_EXEC_I   = 4'h7;
  localparam logic [3:0] S_ALU_WB   = 4'h8;
  localparam logic [3:0] S_BRANCH   = 4'h9;
  localparam logic [3:0] S_JUMP     = 4'hA;
  localparam logic [3:0] S_IDLE     = 4'hB;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // ALU function codes, zero-extended onto alu_op_o
  localparam logic [2:0] ALU_LUI  = 3'b001;
  localparam logic [2:0] ALU_ORI  = 3'b010;
  localparam logic [2:0] ALU_ANDI = 3'b011;
  localparam logic [2:0] ALU_ADDI = 3'b100;
  localparam logic [2:0] ALU_ADD  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_RTYP = 3'b111;

  // Wait counter sized to hold MAX_WAIT; a 1-bit stub when the limit is off
  localparam int              CNT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [3:0]       state, state_next;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] wait_cnt;

  logic             mem_ready;
  logic             wait_state;
  logic             stalled;
  logic             timeout;
  logic             illegal;

  logic             pc_write, ir_write, ior, mem_read, mem_write;
  logic [1:0]       mem_to_reg, reg_dst, alu_src_b, pc_src;
  logic             reg_write, alu_src_a;
  logic [2:0]       alu_fn;

  assign mem_ready  = bus.mem_ready_i;

  // Stall/timeout detection for the three states that wait on memory
  assign wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign stalled    = wait_state && !mem_ready;
  assign timeout    = stalled && (MAX_WAIT > 0) && (wait_cnt == CNT_MAX);

  // ALU function for I-type execution, chosen from the latched opcode
  function automatic logic [2:0] itype_fn(input logic [5:0] op);
    case (op)
      OP_LUI:  itype_fn = ALU_LUI;
      OP_ORI:  itype_fn = ALU_ORI;
      OP_ANDI: itype_fn = ALU_ANDI;
      default: itype_fn = ALU_ADDI;
    endcase
  endfunction

  // Next-state selection; a timeout overrides whatever the state wanted
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_next = state;
    illegal    = 1'b0;
    case (state)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode_i)
          OP_R:                            state_next = S_EXEC_R;
          OP_ADDI, OP_LUI, OP_ORI, OP_ANDI: state_next = S_EXEC_I;
          OP_LW, OP_SW:                    state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                  state_next = S_BRANCH;
          OP_J, OP_JAL:                    state_next = S_JUMP;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: state_next = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_next = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
      S_MEM_WB:   state_next = S_FETCH;
      S_EXEC_R:   state_next = S_ALU_WB;
      S_EXEC_I:   state_next = S_ALU_WB;
      S_ALU_WB:   state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      default:    state_next = S_IDLE;
    endcase
    if (timeout) state_next = S_FETCH;
  end

  // State register; reset parks in IDLE and drops any access in flight
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_next;
  end

  // Opcode register, captured in DECODE for the later states
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                op_q <= 6'h00;
    else if (state == S_DECODE)  op_q <= bus.opcode_i;
  end

  // Wait counter: counts stalled cycles, restarts on any state change or timeout
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                wait_cnt <= '0;
    else if ((state_next != state) || timeout)   wait_cnt <= '0;
    else if (stalled && (wait_cnt != CNT_MAX))   wait_cnt <= wait_cnt + 1'b1;
  end

  // Datapath control decode; unlisted outputs stay 0 in each state
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    ior        = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 2'b00;
    reg_dst    = 2'b00;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_fn     = 3'b000;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_fn    = ALU_ADD;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_fn    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_fn    = ALU_ADD;
      end
      S_MEM_RD: begin
        ior      = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ior       = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_fn    = ALU_RTYP;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_fn    = itype_fn(op_q);
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (op_q == OP_R) ? 2'b01 : 2'b00;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_fn    = ALU_SUB;
        pc_src    = 2'b01;
        pc_write  = ((op_q == OP_BEQ) &&  bus.zero_i) ||
                    ((op_q == OP_BNE) && !bus.zero_i);
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        if (op_q == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
      end
      default: ;
    endcase
  end

  // Drive the bundle
  assign bus.pc_write_o   = pc_write;
  assign bus.ir_write_o   = ir_write;
  assign bus.ior_o        = ior;
  assign bus.mem_read_o   = mem_read;
  assign bus.mem_write_o  = mem_write;
  assign bus.mem_to_reg_o = mem_to_reg;
  assign bus.reg_dst_o    = reg_dst;
  assign bus.reg_write_o  = reg_write;
  assign bus.alu_src_a_o  = alu_src_a;
  assign bus.alu_src_b_o  = alu_src_b;
  assign bus.pc_src_o     = pc_src;
  assign bus.alu_op_o     = ALU_OP_W'(alu_fn);
  assign bus.state_o      = state;
  assign bus.illegal_o    = illegal;
  assign bus.timeout_o    = timeout;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks reset, ADDI, LW with memory
// wait states, SW, branches, R-type, J/JAL, an illegal opcode, a FETCH
// timeout (MAX_WAIT=4) and an asynchronous reset in the middle of a store.
module tb_multicycle_control;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.ALU_OP_W(3)) bus ();

  multicycle_control #(.ALU_OP_W(3), .MAX_WAIT(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // Every output packed together, for all-zero checks
  logic [19:0] all_out;
  assign all_out = {bus.pc_write_o, bus.ir_write_o, bus.ior_o, bus.mem_read_o,
                    bus.mem_write_o, bus.mem_to_reg_o, bus.reg_dst_o,
                    bus.reg_write_o, bus.alu_src_a_o, bus.alu_src_b_o,
                    bus.pc_src_o, bus.alu_op_o, bus.illegal_o, bus.timeout_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: wait for the edge, apply inputs, let the outputs settle
  task automatic cyc(input logic rdy, input logic [5:0] op, input logic z);
    @(posedge clk);
    #1;
    bus.mem_ready_i = rdy;
    bus.opcode_i    = op;
    bus.zero_i      = z;
    #1;
  endtask

  initial begin
    bus.mem_ready_i = 1'b1;
    bus.opcode_i    = 6'h00;
    bus.zero_i      = 1'b0;

    // Reset and release
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.state_o), 32'hB);
    check("rst_outs",  32'(all_out), 32'h0);
    rst_n = 1'b1;
    #1;
    check("idle_state", 32'(bus.state_o), 32'hB);
    check("idle_outs",  32'(all_out), 32'h0);

    // ADDI: 0,1,7,8,0
    cyc(1'b1, 6'h08, 1'b0);
    check("fetch_state", 32'(bus.state_o), 32'h0);
    check("fetch_mrd",   32'(bus.mem_read_o), 32'h1);
    check("fetch_pcw",   32'(bus.pc_write_o), 32'h1);
    check("fetch_irw",   32'(bus.ir_write_o), 32'h1);
    check("fetch_srcb",  32'(bus.alu_src_b_o), 32'h1);
    check("fetch_alu",   32'(bus.alu_op_o), 32'h5);
    cyc(1'b1, 6'h08, 1'b0);
    check("addi_dec",     32'(bus.state_o), 32'h1);
    check("addi_dec_srcb",32'(bus.alu_src_b_o), 32'h3);
    check("addi_dec_ill", 32'(bus.illegal_o), 32'h0);
    cyc(1'b1, 6'h08, 1'b0);
    check("addi_exec",    32'(bus.state_o), 32'h7);
    check("addi_alu",     32'(bus.alu_op_o), 32'h4);
    check("addi_srca",    32'(bus.alu_src_a_o), 32'h1);
    check("addi_exec_rw", 32'(bus.reg_write_o), 32'h0);
    cyc(1'b1, 6'h08, 1'b0);
    check("addi_wb",      32'(bus.state_o), 32'h8);
    check("addi_wb_rw",   32'(bus.reg_write_o), 32'h1);
    check("addi_wb_dst",  32'(bus.reg_dst_o), 32'h0);
    cyc(1'b1, 6'h23, 1'b0);
    check("addi_done",    32'(bus.state_o), 32'h0);

    // LW with three wait cycles in MEM_RD
    cyc(1'b1, 6'h23, 1'b0);
    check("lw_dec",   32'(bus.state_o), 32'h1);
    cyc(1'b1, 6'h23, 1'b0);
    check("lw_addr",  32'(bus.state_o), 32'h2);
    check("lw_srcb",  32'(bus.alu_src_b_o), 32'h2);
    for (int i = 0; i < 4; i++) begin
      cyc((i == 3) ? 1'b1 : 1'b0, 6'h23, 1'b0);
      check("lw_rd_state", 32'(bus.state_o), 32'h3);
      check("lw_rd_ior",   32'(bus.ior_o), 32'h1);
      check("lw_rd_mrd",   32'(bus.mem_read_o), 32'h1);
      check("lw_rd_to",    32'(bus.timeout_o), 32'h0);
    end
    cyc(1'b1, 6'h23, 1'b0);
    check("lw_wb",     32'(bus.state_o), 32'h4);
    check("lw_wb_m2r", 32'(bus.mem_to_reg_o), 32'h1);
    check("lw_wb_rw",  32'(bus.reg_write_o), 32'h1);
    cyc(1'b1, 6'h04, 1'b0);
    check("lw_done",   32'(bus.state_o), 32'h0);

    // BEQ not taken, BNE taken, BEQ taken
    cyc(1'b1, 6'h04, 1'b0);
    check("beq_dec",    32'(bus.state_o), 32'h1);
    cyc(1'b1, 6'h04, 1'b0);
    check("beq_br",     32'(bus.state_o), 32'h9);
    check("beq_nt_pcw", 32'(bus.pc_write_o), 32'h0);
    check("beq_alu",    32'(bus.alu_op_o), 32'h6);
    check("beq_pcsrc",  32'(bus.pc_src_o), 32'h1);
    cyc(1'b1, 6'h05, 1'b0);
    check("beq_done",   32'(bus.state_o), 32'h0);
    cyc(1'b1, 6'h05, 1'b0);
    check("bne_dec",    32'(bus.state_o), 32'h1);
    cyc(1'b1, 6'h05, 1'b0);
    check("bne_br",     32'(bus.state_o), 32'h9);
    check("bne_t_pcw",  32'(bus.pc_write_o), 32'h1);
    cyc(1'b1, 6'h04, 1'b1);
    cyc(1'b1, 6'h04, 1'b1);
    cyc(1'b1, 6'h04, 1'b1);
    check("beq_t_pcw",  32'(bus.pc_write_o), 32'h1);

    // R-type: 0,1,6,8
    cyc(1'b1, 6'h00, 1'b0);
    cyc(1'b1, 6'h00, 1'b0);
    check("r_dec",     32'(bus.state_o), 32'h1);
    cyc(1'b1, 6'h00, 1'b0);
    check("r_exec",    32'(bus.state_o), 32'h6);
    check("r_alu",     32'(bus.alu_op_o), 32'h7);
    check("r_srcb",    32'(bus.alu_src_b_o), 32'h0);
    cyc(1'b1, 6'h00, 1'b0);
    check("r_wb",      32'(bus.state_o), 32'h8);
    check("r_wb_dst",  32'(bus.reg_dst_o), 32'h1);

    // JAL then J
    cyc(1'b1, 6'h03, 1'b0);
    cyc(1'b1, 6'h03, 1'b0);
    check("jal_dec",   32'(bus.state_o), 32'h1);
    cyc(1'b1, 6'h03, 1'b0);
    check("jal_jump",  32'(bus.state_o), 32'hA);
    check("jal_pcw",   32'(bus.pc_write_o), 32'h1);
    check("jal_rw",    32'(bus.reg_write_o), 32'h1);
    check("jal_dst",   32'(bus.reg_dst_o), 32'h2);
    check("jal_m2r",   32'(bus.mem_to_reg_o), 32'h2);
    check("jal_pcsrc", 32'(bus.pc_src_o), 32'h2);
    cyc(1'b1, 6'h02, 1'b0);
    cyc(1'b1, 6'h02, 1'b0);
    cyc(1'b1, 6'h02, 1'b0);
    check("j_jump",    32'(bus.state_o), 32'hA);
    check("j_pcw",     32'(bus.pc_write_o), 32'h1);
    check("j_rw",      32'(bus.reg_write_o), 32'h0);

    // Illegal opcode 3F
    cyc(1'b1, 6'h3F, 1'b0);
    cyc(1'b1, 6'h3F, 1'b0);
    check("ill_dec",   32'(bus.state_o), 32'h1);
    check("ill_pulse", 32'(bus.illegal_o), 32'h1);

    // Back in FETCH with ready low: timeout on the 5th stalled cycle
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 6'h3F, 1'b0);
      check("to_state", 32'(bus.state_o), 32'h0);
      check("to_pcw",   32'(bus.pc_write_o), 32'h0);
      check("to_irw",   32'(bus.ir_write_o), 32'h0);
      check("to_pulse", 32'(bus.timeout_o), (i == 5) ? 32'h1 : 32'h0);
      check("to_ill",   32'(bus.illegal_o), 32'h0);
    end
    cyc(1'b0, 6'h2B, 1'b0);
    check("to_retry",       32'(bus.state_o), 32'h0);
    check("to_retry_pulse", 32'(bus.timeout_o), 32'h0);

    // SW, then an asynchronous reset while the store is waiting
    cyc(1'b1, 6'h2B, 1'b0);
    check("sw_fetch_pcw", 32'(bus.pc_write_o), 32'h1);
    cyc(1'b1, 6'h2B, 1'b0);
    check("sw_dec",   32'(bus.state_o), 32'h1);
    cyc(1'b1, 6'h2B, 1'b0);
    check("sw_addr",  32'(bus.state_o), 32'h2);
    cyc(1'b0, 6'h2B, 1'b0);
    check("sw_wr",    32'(bus.state_o), 32'h5);
    check("sw_mwr",   32'(bus.mem_write_o), 32'h1);
    check("sw_ior",   32'(bus.ior_o), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(bus.state_o), 32'hB);
    check("arst_outs",  32'(all_out), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
